// File: rtl/hmac_msg_streamer.sv
// Buffers a host-loaded message, streams it to the HMAC core over valid/ready/last,
// then captures the resulting tag and compares it against the expected tag.
module hmac_msg_streamer #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [31:0]    wr_data,
  input  logic [AW:0]    msg_len,
  input  logic [511:0]   exp_tag,
  input  logic           start,
  output logic           busy,
  output logic           start_hmac,
  output logic [31:0]    msg_word,
  output logic           msg_valid,
  output logic           msg_last,
  input  logic           msg_ready,
  input  logic           hmac_done,
  input  logic [511:0]   hmac_value,
  output logic [511:0]   tag_out,
  output logic           tag_match,
  output logic           done,
  output logic           err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [511:0]  exp_q, exp_d;
  logic [511:0]  tag_q, tag_d;
  logic          match_q, match_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          start_hmac_q, start_hmac_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          len_ok;
  logic          at_last;

  assign len_ok  = (msg_len != '0) && (msg_len <= (AW+1)'(DEPTH));
  assign at_last = ({1'b0, idx_q} == (len_q - 1'b1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    exp_d        = exp_q;
    tag_d        = tag_q;
    match_d      = match_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    start_hmac_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d        = msg_len;
            exp_d        = exp_tag;
            idx_d        = '0;
            match_d      = 1'b0;
            busy_d       = 1'b1;
            start_hmac_d = 1'b1;
            state_d      = S_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: begin
        valid_d = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (msg_ready) begin
          // idx wraps naturally at DEPTH, so a full buffer never reads out of range
          idx_d = idx_q + 1'b1;
          if (at_last) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (hmac_done) begin
          tag_d   = hmac_value;
          match_d = (hmac_value == exp_q);
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      start_hmac_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tag_q        <= '0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      start_hmac_q <= start_hmac_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tag_q        <= tag_d;
      match_q      <= match_d;
    end
    idx_q <= idx_d;
    len_q <= len_d;
    exp_q <= exp_d;
    cnt_q <= cnt_d;
  end

  // Host writes land only while idle so streamed words cannot change mid-flight
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) mem_q[wr_addr] <= wr_data;
  end

  assign busy       = busy_q;
  assign start_hmac = start_hmac_q;
  assign msg_valid  = valid_q;
  assign msg_word   = valid_q ? mem_q[idx_q] : 32'h0;
  assign msg_last   = valid_q && at_last;
  assign tag_out    = tag_q;
  assign tag_match  = match_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hmac_msg_streamer.sv
// Self-checking bench for hmac_msg_streamer: vector table of transactions plus
// randomized ready/noise, checked against a queue-style reference of the message.
module tb_hmac_msg_streamer;

  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   msg_len;
  logic [511:0]  exp_tag;
  logic          start;
  logic          busy;
  logic          start_hmac;
  logic [31:0]   msg_word;
  logic          msg_valid;
  logic          msg_last;
  logic          msg_ready;
  logic          hmac_done;
  logic [511:0]  hmac_value;
  logic [511:0]  tag_out;
  logic          tag_match;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  hmac_msg_streamer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .exp_tag(exp_tag), .start(start), .busy(busy),
    .start_hmac(start_hmac), .msg_word(msg_word), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_ready(msg_ready), .hmac_done(hmac_done),
    .hmac_value(hmac_value), .tag_out(tag_out), .tag_match(tag_match),
    .done(done), .err(err)
  );

  typedef struct {
    int len;
    int mode;   // 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
    int delay;  // cycles before hmac_done; negative withholds it
    bit flip;
    bit noise;
    bit seqw;
    bit hold;
  } vec_t;

  vec_t         vecs[12];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  ref_mem [DEPTH];
  logic [511:0] model_tag;
  logic         model_match;

  task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    logic [511:0] et;
    logic [511:0] hv;
    logic [31:0]  prev_word;
    bit           ok, prev_stall, bad;
    int           got, cyc;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = v.seqw ? 32'(i + 1) : $urandom;
      ref_mem[i] = wr_data;
      step();
    end
    wr_en = 1'b0;
    if (v.seqw) et = {64{8'hA5}};
    else for (int k = 0; k < 16; k++) et[k*32 +: 32] = $urandom;
    ok      = (v.len >= 1) && (v.len <= DEPTH);
    msg_len = (AW+1)'(v.len);
    exp_tag = et;
    start   = 1'b1;
    step();
    start = 1'b0;
    if (!ok) begin
      chk1("badlen_err", err, 1'b1);
      chk1("badlen_busy", busy, 1'b0);
      chk1("badlen_start_hmac", start_hmac, 1'b0);
      step();
      chk1("badlen_err_clear", err, 1'b0);
      chk1("badlen_idle_busy", busy | start_hmac, 1'b0);
      return;
    end
    chk1("start_hmac_pulse", start_hmac, 1'b1);
    chk1("start_busy", busy, 1'b1);
    chk1("start_valid_low", msg_valid, 1'b0);
    chk1("start_match_clr", tag_match, 1'b0);
    got = 0; cyc = 0; prev_stall = 1'b0; prev_word = '0; bad = 1'b0;
    while (got < v.len && cyc < 400) begin
      step();
      if (!busy || !msg_valid || start_hmac || done || err || tag_out !== model_tag) bad = 1'b1;
      case (v.mode)
        0:       msg_ready = 1'b1;
        1:       msg_ready = (cyc % 3) == 0;
        default: msg_ready = 1'($urandom_range(0, 1));
      endcase
      if (v.noise) begin
        hmac_done = 1'($urandom_range(0, 1));
        for (int k = 0; k < 16; k++) hmac_value[k*32 +: 32] = $urandom;
        wr_en   = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = $urandom;
      end
      if (prev_stall) chkw("stall_word_stable", 512'(msg_word), 512'(prev_word));
      if (msg_ready) begin
        chkw("xfer_word", 512'(msg_word), 512'(ref_mem[got]));
        chk1("xfer_last", msg_last, got == v.len - 1);
        got++;
      end else begin
        chk1("stall_last", msg_last, got == v.len - 1);
      end
      prev_stall = !msg_ready;
      prev_word  = msg_word;
      cyc++;
    end
    chk1("stream_flags", bad, 1'b0);
    chkw("xfer_count", 512'(got), 512'(v.len));
    hmac_done = 1'b0;
    wr_en     = 1'b0;
    step();
    msg_ready = 1'b0;
    chk1("wait_valid_low", msg_valid, 1'b0);
    chk1("wait_last_low", msg_last, 1'b0);
    chk1("wait_busy", busy, 1'b1);
    if (v.delay < 0) begin
      bad = 1'b0;
      for (int k = 2; k <= TIMEOUT; k++) begin
        step();
        if (err || !busy || done) bad = 1'b1;
      end
      chk1("timeout_early", bad, 1'b0);
      step();
      chk1("timeout_err", err, 1'b1);
      chk1("timeout_busy", busy, 1'b0);
      chk1("timeout_done", done, 1'b0);
      chkw("timeout_tag_kept", tag_out, model_tag);
      step();
      chk1("timeout_err_clear", err, 1'b0);
      return;
    end
    for (int d = 0; d < v.delay; d++) step();
    hv = v.flip ? (et ^ 512'd1) : et;
    hmac_done  = 1'b1;
    hmac_value = hv;
    step();
    hmac_done = 1'b0;
    model_tag   = hv;
    model_match = (hv == et);
    chk1("finish_done", done, 1'b1);
    chk1("finish_busy", busy, 1'b1);
    chk1("finish_err", err, 1'b0);
    chkw("finish_tag", tag_out, model_tag);
    chk1("finish_match", tag_match, model_match);
    if (v.hold) begin
      start = 1'b1;
      step();
      chk1("hold_idle_busy", busy, 1'b0);
      step();
      start = 1'b0;
      chk1("hold_restart", start_hmac, 1'b1);
      msg_ready = 1'b1;
      step();
      step();
      chk1("midstream_valid", msg_valid, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_tag   = '0;
      model_match = 1'b0;
      chk1("rst_valid", msg_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_last", msg_last, 1'b0);
      chkw("rst_tag", tag_out, model_tag);
      msg_ready = 1'b0;
      step();
      chk1("rst_stays_idle", busy | msg_valid, 1'b0);
      return;
    end
    step();
    chk1("post_done_clear", done, 1'b0);
    chk1("post_busy", busy, 1'b0);
    chkw("post_tag_hold", tag_out, model_tag);
    chk1("post_match_hold", tag_match, model_match);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    exp_tag = '0; start = 1'b0; msg_ready = 1'b0; hmac_done = 1'b0; hmac_value = '0;
    model_tag = '0; model_match = 1'b0;
    vecs[0]  = '{4, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{DEPTH + 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{DEPTH, 2, 5, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 6; i < 10; i++)
      vecs[i] = '{int'($urandom_range(1, DEPTH)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), 1'b0, 1'b0};
    vecs[10] = '{DEPTH, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1};
    step();
    step();
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_start_hmac", start_hmac, 1'b0);
    chk1("reset_valid", msg_valid, 1'b0);
    chk1("reset_last", msg_last, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    chk1("reset_match", tag_match, 1'b0);
    chkw("reset_tag", tag_out, 512'd0);
    chkw("reset_word", 512'(msg_word), 512'd0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 12; i++) run_txn(vecs[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
